// File: rtl/weight_serializer.sv
// weight_serializer: streams a captured flat bus of N=SIZE*COUNT 32-bit words out one word per cycle over valid/ready.
module weight_serializer #(
    parameter int SIZE = 2,
    parameter int COUNT = 1,
    localparam int N = SIZE * COUNT,
    localparam int IW = $clog2(N) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*32-1:0] in_data,
    output logic [31:0]     out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic [IW-1:0]   out_index,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t state_q, state_d;
    logic [N*32-1:0] shadow_q, shadow_d;
    logic [31:0] data_q, data_d;
    logic valid_q, valid_d, done_q, done_d;
    logic [IW-1:0] idx_q, idx_d, nxt;
    assign out_data = data_q;
    assign out_valid = valid_q;
    assign out_index = idx_q;
    assign done = done_q;
    assign busy = state_q != IDLE;
    assign out_last = (state_q == SEND) && (idx_q == IW'(N - 1));
    assign nxt = idx_q + 1'b1;
    always_comb begin
        state_d = state_q;
        shadow_d = shadow_q;
        data_d = data_q;
        valid_d = valid_q;
        idx_d = idx_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                shadow_d = in_data;
                data_d = in_data[31:0];
                idx_d = '0;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: if (valid_q && out_ready) begin
                if (out_last) begin
                    valid_d = 1'b0;
                    data_d = '0;
                    idx_d = '0;
                    done_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = nxt;
                    data_d = 32'(shadow_q >> {nxt, 5'd0});
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shadow_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            idx_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shadow_q <= shadow_d;
            data_q <= data_d;
            valid_q <= valid_d;
            idx_q <= idx_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_weight_serializer.sv
// tb_weight_serializer: directed checks of three serializer configurations (N=2, N=4, N=1).
module tb_weight_serializer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start2, ready2, valid2, last2, busy2, done2;
    logic [63:0] in2;
    logic [31:0] data2;
    logic [1:0] idx2;

    logic start4, ready4, valid4, last4, busy4, done4;
    logic [127:0] in4;
    logic [31:0] data4;
    logic [2:0] idx4;

    logic start1, ready1, valid1, last1, busy1, done1;
    logic [31:0] in1;
    logic [31:0] data1;
    logic [0:0] idx1;

    weight_serializer #(.SIZE(2), .COUNT(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .in_data(in2), .out_data(data2), .out_valid(valid2),
        .out_ready(ready2), .out_last(last2), .out_index(idx2), .busy(busy2), .done(done2));
    weight_serializer #(.SIZE(2), .COUNT(2)) u4 (
        .clk(clk), .rst(rst), .start(start4), .in_data(in4), .out_data(data4), .out_valid(valid4),
        .out_ready(ready4), .out_last(last4), .out_index(idx4), .busy(busy4), .done(done4));
    weight_serializer #(.SIZE(1), .COUNT(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .in_data(in1), .out_data(data1), .out_valid(valid1),
        .out_ready(ready1), .out_last(last1), .out_index(idx1), .busy(busy1), .done(done1));

    int checks = 0;
    int failures = 0;
    int xfers4 = 0;
    int dones4 = 0;
    logic [31:0] seen4 [0:3];

    always @(posedge clk) begin
        if (!rst && valid4 && ready4) begin
            if (xfers4 < 4) seen4[xfers4] <= data4;
            xfers4 <= xfers4 + 1;
        end
        if (done4) dones4 <= dones4 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        start2 = 1'b1; start4 = 1'b1; start1 = 1'b1;
        ready2 = 1'b1; ready4 = 1'b1; ready1 = 1'b1;
        in2 = {32'hDEADBEEF, 32'h12345678};
        in4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        in1 = 32'hCAFEF00D;
        tick();
        chk("rst_c1_u4", {data4, valid4, last4, idx4, busy4, done4}, 64'd0);
        tick();
        chk("rst_u2", {data2, valid2, last2, idx2, busy2, done2}, 64'd0);
        chk("rst_u4", {data4, valid4, last4, idx4, busy4, done4}, 64'd0);
        chk("rst_u1", {data1, valid1, last1, idx1, busy1, done1}, 64'd0);
        start2 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_after_rst", {valid2, valid4, valid1, busy2, busy4, busy1}, 64'd0);
        xfers4 = 0;
        dones4 = 0;

        // Basic frame, N=2
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("basic_w0", {data2, valid2, last2, idx2, busy2, done2}, {32'h12345678, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0});
        tick();
        chk("basic_w1", {data2, valid2, last2, idx2, busy2, done2}, {32'hDEADBEEF, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0});
        tick();
        chk("basic_done", {data2, valid2, last2, idx2, busy2, done2}, {32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1});
        tick();
        chk("basic_idle", {busy2, done2, valid2}, 64'd0);

        // Backpressure, capture isolation and ignored start, N=4
        start4 = 1'b1;
        tick();
        chk("bp_w0", {data4, valid4, idx4}, {32'h11111111, 1'b1, 3'd0});
        in4 = '0;
        tick();
        chk("bp_w1", {data4, valid4, idx4, last4}, {32'h22222222, 1'b1, 3'd1, 1'b0});
        start4 = 1'b0;
        ready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i), {data4, valid4, idx4, last4}, {32'h22222222, 1'b1, 3'd1, 1'b0});
        end
        ready4 = 1'b1;
        tick();
        chk("bp_w2", {data4, valid4, idx4, last4}, {32'h33333333, 1'b1, 3'd2, 1'b0});
        tick();
        chk("bp_w3", {data4, valid4, idx4, last4}, {32'h44444444, 1'b1, 3'd3, 1'b1});
        tick();
        chk("bp_done", {data4, valid4, idx4, last4, busy4, done4}, {32'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1});
        for (int i = 0; i < 4; i++) tick();
        chk("bp_no_second", {valid4, busy4, done4}, 64'd0);
        chk("bp_xfers", 64'(xfers4), 64'd4);
        chk("bp_dones", 64'(dones4), 64'd1);
        chk("bp_order", {seen4[0], seen4[1]}, {32'h11111111, 32'h22222222});
        chk("bp_order2", {seen4[2], seen4[3]}, {32'h33333333, 32'h44444444});

        // Mid-transfer reset
        in4 = {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001};
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("mr_w0", {data4, idx4}, {32'hA0000001, 3'd0});
        tick();
        chk("mr_w1", {data4, idx4, valid4}, {32'hA0000002, 3'd1, 1'b1});
        rst = 1'b1;
        tick();
        chk("mr_rst", {data4, valid4, last4, idx4, busy4, done4}, 64'd0);
        rst = 1'b0;
        tick();
        chk("mr_no_done", {data4, valid4, last4, idx4, busy4, done4}, 64'd0);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("mr_restart_w0", {data4, valid4, idx4, last4}, {32'hA0000001, 1'b1, 3'd0, 1'b0});
        tick();
        tick();
        tick();
        chk("mr_w3", {data4, valid4, idx4, last4}, {32'hA0000004, 1'b1, 3'd3, 1'b1});
        tick();
        chk("mr_done", {done4, valid4}, {1'b1, 1'b0});
        tick();
        chk("mr_dones", 64'(dones4), 64'd2);

        // Single-word frame, N=1
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("one_w0", {data1, valid1, last1, idx1, busy1, done1}, {32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        tick();
        chk("one_done", {data1, valid1, last1, idx1, busy1, done1}, {32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        tick();
        chk("one_idle", {busy1, done1, valid1}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
